utx_piso: RTL and testbench
===========================

// Module: utx_piso
// PURPOSE
//  UART transmit datapath: double-buffered parallel-in/serial-out stage directly downstream of ufsm.
//  Captures host bytes on d_ready, holds one byte pending, and drives registered tx from the ufsm sel code.
//  LSB-first, one bit per enabled clock. Flags overrun, underrun and short frames.
// PARAMETERS
//  WIDTH   8  data bits per frame; must match ufsm WIDTH
//  CW      $clog2(WIDTH+1)  bit_cnt width (derived localparam, not overridable)
// PORTS
//  clk       in   1      system clock, rising edge
//  rstn      in   1      asynchronous active-low reset
//  en        in   1      bit-advance enable (same net as ufsm en)
//  d_ready   in   1      host byte valid (same net as ufsm d_ready), level-sampled
//  data_in   in   WIDTH  host byte, sampled when d_ready=1
//  sel       in   2      ufsm state code: 00 idle, 01 start, 10 data, 11 stop
//  clr_err   in   1      synchronous clear of ovr/udr/frm_err
//  tx        out  1      serial line, registered
//  busy      out  1      frame in progress
//  hold_full out  1      holding register occupied
//  bit_cnt   out  CW     data bits shifted in current frame
//  frame_done out 1      one-cycle pulse, good frame end
//  ovr       out  1      sticky overrun
//  udr       out  1      sticky underrun
//  frm_err   out  1      sticky short/long frame
// BEHAVIOUR
//  Reset: tx=1, busy=0, hold_full=0, bit_cnt=0, frame_done=0, ovr=udr=frm_err=0, hold=shift=all-ones, sel_q=00.
//  Holding register, independent of en:
//   - d_ready=1 and hold_full=0 -> hold<=data_in, hold_full<=1.
//   - d_ready=1, hold_full=1, no transfer this cycle -> data dropped, ovr<=1.
//   - d_ready=1 on the transfer cycle -> transfer takes the old hold; data_in is captured; hold_full stays 1; no ovr.
//  Transfer:
//   - Condition: en=1, sel=01, sel_q!=01 (first start cycle).
//   - shift<=hold, hold_full<=0, bit_cnt<=0, busy<=1.
//   - hold_full=0 at transfer -> shift<=all-ones, udr<=1; the frame still runs.
//  All tx/shift/bit_cnt updates require en=1. With en=0, tx, shift, bit_cnt and sel_q hold.
//  Latency: tx reflects sel one clock later.
//   - sel=00: tx<=1.
//   - sel=01: tx<=0.
//   - sel=10: tx<=shift[0]; shift<={1'b1,shift[WIDTH-1:1]}; bit_cnt<=bit_cnt+1, saturating at WIDTH.
//     Data bits beyond WIDTH drive 1.
//   - sel=11: tx<=1.
//  Frame end, on the first en cycle with sel=11 after sel_q!=11:
//   - bit_cnt==WIDTH -> frame_done=1 for one clock.
//   - bit_cnt!=WIDTH (short frame, or a data cycle attempted past saturation) -> frm_err<=1, no frame_done.
//   - busy<=0 when sel returns to 00 (en=1).
//  sel_q<=sel on each en cycle. sel jumping 10->01 with no stop is a new transfer; the old frame is abandoned, frm_err<=1.
//  clr_err=1 clears the sticky flags. A same-cycle set wins over clr_err.
//  rstn low mid-frame: immediate return to reset values; the pending hold byte is lost.
// TESTING
//  1. WIDTH=8, d_ready pulse with 0xA5, sel 01, 10x8, 11, en=1 -> tx 0,1,0,1,0,0,1,0,1,1; frame_done once; bit_cnt=8.
//  2. d_ready 0x3C, then d_ready 0x55 before start -> ovr=1; frame carries 0x3C; hold_full=0 after transfer.
//  3. Start with hold_full=0 -> udr=1; tx=0 then 1x8; frame_done=1.
//  4. en toggled 0/1 each clock mid-data -> tx sequence identical to test 1, stretched; no flags set.
//  5. sel 01, 10x5, 11 -> frm_err=1; frame_done stays 0; clr_err clears it next clock.
//  6. rstn low after 3 data bits -> tx=1, busy=0, hold_full=0 asynchronously; next 0xFF frame sends correctly.

Source files
------------

// File: rtl/utx_piso.sv
// utx_piso: double-buffered UART transmit PISO driven by the ufsm sel code.
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   en                 bit-advance enable shared with ufsm
//   d_ready, data_in   host byte valid (level-sampled) and byte
//   sel                ufsm state code: 00 idle, 01 start, 10 data, 11 stop
//   clr_err            synchronous clear of ovr/udr/frm_err
//   tx                 registered serial line
//   busy, hold_full    frame in progress, holding register occupied
//   bit_cnt            data bits shifted in current frame (saturates at WIDTH)
//   frame_done         one-cycle pulse at a good frame end
//   ovr, udr, frm_err  sticky overrun, underrun, short/long frame
module utx_piso #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             d_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       sel,
    input  logic             clr_err,
    output logic             tx,
    output logic             busy,
    output logic             hold_full,
    output logic [CW-1:0]    bit_cnt,
    output logic             frame_done,
    output logic             ovr,
    output logic             udr,
    output logic             frm_err
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_START = 2'b01, S_DATA = 2'b10, S_STOP = 2'b11} sel_e;

    sel_e             sel_c, sel_q, sel_d;
    logic             tx_q, tx_d, busy_q, busy_d, hold_full_q, hold_full_d, done_q, done_d;
    logic             ovr_q, ovr_d, udr_q, udr_d, frm_q, frm_d, extra_q, extra_d;
    logic [WIDTH-1:0] hold_q, hold_d, shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             xfer, stop_edge, cnt_full, set_ovr, set_udr, set_frm;

    assign sel_c = sel_e'(sel);

    always_comb begin
        xfer      = en && sel_c == S_START && sel_q != S_START;
        stop_edge = en && sel_c == S_STOP && sel_q != S_STOP;
        cnt_full  = cnt_q == CW'(WIDTH);
        set_ovr   = d_ready && hold_full_q && !xfer;
        set_udr   = xfer && !hold_full_q;
        // extra_q marks a data cycle attempted after saturation, so a long frame is also an error
        set_frm   = (xfer && sel_q == S_DATA) || (stop_edge && (!cnt_full || extra_q));
        done_d    = stop_edge && cnt_full && !extra_q;
        hold_d      = (d_ready && (!hold_full_q || xfer)) ? data_in : hold_q;
        hold_full_d = xfer ? d_ready : (hold_full_q || d_ready);
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        sel_d   = sel_q;
        extra_d = extra_q;
        if (en) begin
            sel_d = sel_c;
            tx_d  = sel_c == S_DATA ? shift_q[0] : sel_c != S_START;
            if (sel_c == S_DATA) begin
                shift_d = {1'b1, shift_q[WIDTH-1:1]};
                cnt_d   = cnt_full ? cnt_q : cnt_q + 1'b1;
                extra_d = extra_q || cnt_full;
            end
            if (sel_c == S_IDLE) busy_d = 1'b0;
        end
        if (xfer) begin
            shift_d = hold_full_q ? hold_q : '1;
            cnt_d   = '0;
            extra_d = 1'b0;
            busy_d  = 1'b1;
        end
        ovr_d = (ovr_q && !clr_err) || set_ovr;
        udr_d = (udr_q && !clr_err) || set_udr;
        frm_d = (frm_q && !clr_err) || set_frm;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
            frm_q       <= 1'b0;
            extra_q     <= 1'b0;
            hold_q      <= '1;
            shift_q     <= '1;
            sel_q       <= S_IDLE;
        end else begin
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
            frm_q       <= frm_d;
            extra_q     <= extra_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            sel_q       <= sel_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign hold_full  = hold_full_q;
    assign bit_cnt    = cnt_q;
    assign frame_done = done_q;
    assign ovr        = ovr_q;
    assign udr        = udr_q;
    assign frm_err    = frm_q;
endmodule

// File: tb/tb_utx_piso.sv
// tb_utx_piso: directed bench for utx_piso with a frame-level reference model.
module tb_utx_piso;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b0, d_ready = 1'b0, clr_err = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [1:0]   sel = 2'b00;
    logic         tx, busy, hold_full, frame_done, ovr, udr, frm_err;
    logic [3:0]   bit_cnt;

    utx_piso #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .en(en), .d_ready(d_ready), .data_in(data_in),
        .sel(sel), .clr_err(clr_err), .tx(tx), .busy(busy), .hold_full(hold_full),
        .bit_cnt(bit_cnt), .frame_done(frame_done), .ovr(ovr), .udr(udr), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d", n, a, e);
        end
    endtask

    // Reference model: tracks the frame byte and a plain count of data cycles
    logic         e_tx = 1, e_busy = 0, e_hf = 0, e_done = 0, e_ovr = 0, e_udr = 0, e_frm = 0;
    logic [W-1:0] m_hold = '1, m_frame = '1;
    logic [1:0]   m_psel = 0;
    int           m_k = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_tx = 1; e_busy = 0; e_hf = 0; e_done = 0; e_ovr = 0; e_udr = 0; e_frm = 0;
            m_hold = '1; m_frame = '1; m_psel = 0; m_k = 0;
        end else begin
            logic tr, st, s_ovr, s_udr, s_frm;
            tr = en && sel == 2'b01 && m_psel != 2'b01;
            st = en && sel == 2'b11 && m_psel != 2'b11;
            s_ovr = 0; s_udr = 0; s_frm = 0; e_done = 0;
            if (tr) begin
                m_frame = e_hf ? m_hold : '1;
                s_udr = !e_hf;
                s_frm = m_psel == 2'b10;
                m_k = 0;
                e_busy = 1;
                if (d_ready) m_hold = data_in;
                e_hf = d_ready;
            end else if (d_ready) begin
                if (e_hf) s_ovr = 1;
                else begin
                    m_hold = data_in;
                    e_hf = 1;
                end
            end
            if (en) begin
                if (st) begin
                    if (m_k == W) e_done = 1;
                    else s_frm = 1;
                end
                if (sel == 2'b00) begin e_tx = 1; e_busy = 0; end
                else if (sel == 2'b01) e_tx = 0;
                else if (sel == 2'b11) e_tx = 1;
                else begin
                    e_tx = m_k < W ? m_frame[m_k] : 1'b1;
                    m_k++;
                end
                m_psel = sel;
            end
            e_ovr = (e_ovr && !clr_err) || s_ovr;
            e_udr = (e_udr && !clr_err) || s_udr;
            e_frm = (e_frm && !clr_err) || s_frm;
        end
    end

    always @(negedge clk) begin
        if (rstn && chk_on) begin
            chk("tx", tx, e_tx);
            chk("busy", busy, e_busy);
            chk("hold_full", hold_full, e_hf);
            chk("bit_cnt", bit_cnt, m_k > W ? W : m_k);
            chk("frame_done", frame_done, e_done);
            chk("ovr", ovr, e_ovr);
            chk("udr", udr, e_udr);
            chk("frm_err", frm_err, e_frm);
        end
    end

    int cap, ncap, ndone, stop_cnt;

    task automatic step(input logic e, input logic [1:0] s, input logic dr = 0,
                        input logic [W-1:0] d = '0, input logic c = 0);
        en = e; sel = s; d_ready = dr; data_in = d; clr_err = c;
        @(posedge clk);
        #2;
    endtask

    task automatic cap_tx();
        cap |= int'(tx) << ncap;
        ncap++;
        ndone += int'(frame_done);
    endtask

    task automatic frame(input int nd, input logic dr = 0, input logic [W-1:0] d = '0);
        cap = 0; ncap = 0; ndone = 0;
        step(1, 2'b01, dr, d); cap_tx();
        repeat (nd) begin step(1, 2'b10); cap_tx(); end
        step(1, 2'b11); cap_tx();
        stop_cnt = bit_cnt;
        step(1, 2'b00);
        ndone += int'(frame_done);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_hf", hold_full, 0);
        chk("rst_cnt", bit_cnt, 0); chk("rst_done", frame_done, 0);
        chk("rst_ovr", ovr, 0); chk("rst_udr", udr, 0); chk("rst_frm", frm_err, 0);
        rstn = 1;
        chk_on = 1;
        step(1, 2'b00);
        // 1: basic 0xA5 frame
        step(1, 2'b00, 1, 8'hA5);
        frame(8);
        chk("t1_seq", cap, 'h34A); chk("t1_done", ndone, 1); chk("t1_cnt", stop_cnt, 8);
        // 2: overrun, frame carries first byte
        step(1, 2'b00, 1, 8'h3C);
        step(1, 2'b00, 1, 8'h55);
        chk("t2_ovr", ovr, 1);
        frame(8);
        chk("t2_seq", cap, 632); chk("t2_hf", hold_full, 0); chk("t2_done", ndone, 1);
        // 3: underrun sends all-ones
        step(1, 2'b00, 0, 0, 1);
        frame(8);
        chk("t3_udr", udr, 1); chk("t3_seq", cap, 'h3FE); chk("t3_done", ndone, 1);
        // 4: en toggled mid-data
        step(1, 2'b00, 0, 0, 1);
        step(1, 2'b00, 1, 8'hA5);
        cap = 0; ncap = 0; ndone = 0;
        step(1, 2'b01); cap_tx();
        repeat (8) begin step(0, 2'b10); step(1, 2'b10); cap_tx(); end
        step(0, 2'b11); step(1, 2'b11); cap_tx();
        step(0, 2'b00); step(1, 2'b00); ndone += int'(frame_done);
        chk("t4_seq", cap, 'h34A); chk("t4_done", ndone, 1);
        chk("t4_ovr", ovr, 0); chk("t4_udr", udr, 0); chk("t4_frm", frm_err, 0);
        // 5: short frame
        step(1, 2'b00, 1, 8'h96);
        frame(5);
        chk("t5_frm", frm_err, 1); chk("t5_done", ndone, 0);
        step(1, 2'b00, 0, 0, 1);
        chk("t5_clr", frm_err, 0);
        // 6: async reset mid-frame with a pending byte
        step(1, 2'b00, 1, 8'h81);
        step(1, 2'b01, 1, 8'h42);
        repeat (3) step(1, 2'b10);
        chk("t6_hf_pre", hold_full, 1);
        rstn = 0;
        #1;
        chk("t6_tx", tx, 1); chk("t6_busy", busy, 0); chk("t6_hf", hold_full, 0);
        @(posedge clk);
        #2;
        rstn = 1;
        step(1, 2'b00);
        step(1, 2'b00, 1, 8'hFF);
        frame(8);
        chk("t6_seq", cap, 'h3FE); chk("t6_done", ndone, 1); chk("t6_udr", udr, 0);
        step(1, 2'b00);
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
